// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: control inputs and row outputs of the sequencer.
// master drives start/pause/abort; slave is the sequencer.
interface truth_table_sequencer_if #(
  parameter int unsigned N_INPUTS = 3
);
  logic                start;
  logic                pause;
  logic                abort;
  logic [N_INPUTS-1:0] vec;
  logic [N_INPUTS-1:0] idx;
  logic                vec_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, pause, abort,
    input  vec, idx, vec_valid, busy, done
  );

  modport slave (
    input  start, pause, abort,
    output vec, idx, vec_valid, busy, done
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: steps an N-bit vector through all 2^N rows, DWELL cycles each.
// Define TTS_GRAY_EN to present rows in Gray-code order (idx stays binary).
module truth_table_sequencer #(
  parameter int unsigned N_INPUTS = 3,
  parameter int unsigned DWELL    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sequencer_if.slave bus
);

  localparam logic [N_INPUTS-1:0] LAST   = {N_INPUTS{1'b1}};
  localparam logic [N_INPUTS-1:0] ONE    = N_INPUTS'(1);
  localparam logic [15:0]         RELOAD = 16'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [N_INPUTS-1:0] row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = RELOAD;
        end
      end
      RUN: begin
        // abort outranks pause, pause outranks counting
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (bus.pause) begin
          cnt_d = cnt_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (idx_q != LAST) begin
          idx_d = idx_q + ONE;
          cnt_d = RELOAD;
        end else begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef TTS_GRAY_EN
  assign row = idx_q ^ (idx_q >> 1);
`else
  assign row = idx_q;
`endif

  assign bus.vec       = (state_q == RUN) ? row : '0;
  assign bus.idx       = (state_q == RUN) ? idx_q : '0;
  assign bus.vec_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed checks of sweep, pause, abort,
// back-to-back, reset and row ordering.
module tb_truth_table_sequencer;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [8:0] got;
  logic [8:0] exp;
  logic [2:0] prev;
  int         bad;

`ifdef TTS_GRAY_EN
  logic [2:0] tbl [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                          3'b110, 3'b111, 3'b101, 3'b100};
`else
  logic [2:0] tbl [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                          3'b100, 3'b101, 3'b110, 3'b111};
`endif

  truth_table_sequencer_if #(.N_INPUTS(3)) ia ();
  truth_table_sequencer_if #(.N_INPUTS(3)) ib ();
  truth_table_sequencer_if #(.N_INPUTS(3)) ic ();

  truth_table_sequencer #(.N_INPUTS(3), .DWELL(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  truth_table_sequencer #(.N_INPUTS(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );
  truth_table_sequencer #(.N_INPUTS(3), .DWELL(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    ia.start = 0; ia.pause = 0; ia.abort = 0;
    ib.start = 0; ib.pause = 0; ib.abort = 0;
    ic.start = 0; ic.pause = 0; ic.abort = 0;
    #1;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_a got=%b exp=%b", got, 9'd0);
    end
    got = {ib.vec, ib.idx, ib.vec_valid, ib.busy, ib.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_b got=%b exp=%b", got, 9'd0);
    end
    ia.start = 1;
    @(posedge clk);
    #1;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=%b", got, 9'd0);
    end
    ia.start = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {ic.vec, ic.idx, ic.vec_valid, ic.busy, ic.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=%b", got, 9'd0);
    end
  endtask

  task automatic test_basic();
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    for (int p = 0; p < 80; p++) begin
      got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
      exp = {tbl[p/10], 3'(p/10), 3'b110};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", p, got, exp);
      end
      @(negedge clk);
    end
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'b000_000_001) begin
      n_fail++;
      $display("FAIL basic_done got=%b exp=%b", got, 9'b000_000_001);
    end
    @(negedge clk);
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL basic_idle got=%b exp=%b", got, 9'd0);
    end
  endtask

  task automatic test_pause();
    int q[$];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < ((r == 3) ? 15 : 10); c++)
        q.push_back(r);
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    for (int p = 0; p < 85; p++) begin
      got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
      exp = {tbl[q[p]], 3'(q[p]), 3'b110};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pause cyc=%0d got=%b exp=%b", p, got, exp);
      end
      ia.pause = (p >= 32 && p <= 36);
      @(negedge clk);
    end
    ia.pause = 0;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'b000_000_001) begin
      n_fail++;
      $display("FAIL pause_done got=%b exp=%b", got, 9'b000_000_001);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    for (int p = 0; p < 54; p++) begin
      got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
      exp = {tbl[p/10], 3'(p/10), 3'b110};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_run cyc=%0d got=%b exp=%b", p, got, exp);
      end
      if (p == 53) begin
        ia.abort = 1;
        ia.pause = 1;
      end
      @(negedge clk);
    end
    ia.abort = 0;
    ia.pause = 0;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL abort_stop got=%b exp=%b", got, 9'd0);
    end
    bad = 0;
    for (int p = 0; p < 90; p++) begin
      if (ia.done || ia.vec_valid || ia.busy) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet active_cycles=%0d exp=0", bad);
    end
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    exp = {tbl[0], 3'd0, 3'b110};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL abort_restart got=%b exp=%b", got, exp);
    end
    ia.abort = 1;
    @(negedge clk);
    ia.abort = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    ib.start = 1;
    @(negedge clk);
    for (int p = 0; p < 21; p++) begin
      got = {ib.vec, ib.idx, ib.vec_valid, ib.busy, ib.done};
      if (p < 8)
        exp = {tbl[p], 3'(p), 3'b110};
      else if (p >= 10 && p < 18)
        exp = {tbl[p-10], 3'(p-10), 3'b110};
      else if (p == 8 || p == 18)
        exp = 9'b000_000_001;
      else
        exp = 9'd0;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", p, got, exp);
      end
      if (p == 10) ib.start = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    for (int p = 0; p < 64; p++) begin
      got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
      exp = {tbl[p/10], 3'(p/10), 3'b110};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rstmid_run cyc=%0d got=%b exp=%b", p, got, exp);
      end
      if (p < 63) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got=%b exp=%b", got, 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      if (ia.done || ia.vec_valid || ia.busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet active_cycles=%0d exp=0", bad);
    end
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    got = {ia.vec, ia.idx, ia.vec_valid, ia.busy, ia.done};
    exp = {tbl[0], 3'd0, 3'b110};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL rstmid_restart got=%b exp=%b", got, exp);
    end
    ia.abort = 1;
    @(negedge clk);
    ia.abort = 0;
  endtask

  task automatic test_order();
    ic.start = 1;
    @(negedge clk);
    ic.start = 0;
    prev = ic.vec;
    for (int p = 0; p < 16; p++) begin
      got = {ic.vec, ic.idx, ic.vec_valid, ic.busy, ic.done};
      exp = {tbl[p/2], 3'(p/2), 3'b110};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL order cyc=%0d got=%b exp=%b", p, got, exp);
      end
`ifdef TTS_GRAY_EN
      if (p > 0 && (p % 2) == 0) begin
        n_checks++;
        if ($countones(ic.vec ^ prev) !== 1) begin
          n_fail++;
          $display("FAIL gray_step cyc=%0d prev=%b now=%b", p, prev, ic.vec);
        end
      end
`endif
      prev = ic.vec;
      @(negedge clk);
    end
    got = {ic.vec, ic.idx, ic.vec_valid, ic.busy, ic.done};
    n_checks++;
    if (got !== 9'b000_000_001) begin
      n_fail++;
      $display("FAIL order_done got=%b exp=%b", got, 9'b000_000_001);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_pause();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_order();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
